// File: rtl/cvp14_mmio_pkg.sv
// Shared constants for the CVP14 MMIO responder: register offsets, STATUS layout
// and the default window base and TX FIFO depth.
package cvp14_mmio_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT  = 16'hFF00;
    localparam int          MMIO_DEPTH_DEFAULT = 8;

    localparam logic [3:0] OFF_TXDATA = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_TIMER  = 4'd2;
    localparam logic [3:0] OFF_CMP    = 4'd3;
    localparam logic [3:0] OFF_CTRL   = 4'd4;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_IRQ     = 7;

    function automatic logic [15:0] pack_status(input logic irq, input logic [3:0] cnt,
                                                input logic ovf, input logic full,
                                                input logic empty);
        logic [15:0] s;
        s                         = '0;
        s[ST_IRQ]                 = irq;
        s[ST_CNT_LSB+3:ST_CNT_LSB] = cnt;
        s[ST_OVF]                 = ovf;
        s[ST_FULL]                = full;
        s[ST_EMPTY]               = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// TX FIFO for the MMIO responder: circular storage with wrap-around pointers,
// occupancy count, and a drop pulse when a push hits a full FIFO without a pop.
module mmio_fifo
    import cvp14_mmio_pkg::*;
#(
    parameter int DEPTH = MMIO_DEPTH_DEFAULT,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   din,
    input  logic          pop,
    output logic [15:0]   dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          push_ok, pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;

    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    // Gate the head so the output reads zero while the FIFO is empty or held in reset.
    assign dout = empty ? 16'h0000 : mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (pop_ok)
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mmio_resp.sv
// 16-word MMIO responder for CVP14: TX FIFO front end, free-running timer with
// compare interrupt, and a one-cycle registered read port with a window-hit select.
module mmio_resp
    import cvp14_mmio_pkg::*;
#(
    parameter logic [15:0] BASE  = MMIO_BASE_DEFAULT,
    parameter int          DEPTH = MMIO_DEPTH_DEFAULT
) (
    input  logic        Clk1,
    input  logic        Reset_n,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Sel,
    output logic [15:0] TxData,
    output logic        TxValid,
    input  logic        TxReady,
    output logic        Irq
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          hit, wr_hit, rd_hit;
    logic [3:0]    off;
    logic [15:0]   rdata;
    logic [15:0]   timer_reg, cmp_reg, dout_reg;
    logic          ten_reg, ovf_reg, irq_reg, sel_reg;
    logic          match, irq_clr, ovf_clr;
    logic          fifo_push, fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [15:0]   cnt_ext;

    assign hit    = (Addr[15:4] == BASE[15:4]);
    assign off    = Addr[3:0];
    assign wr_hit = WR && hit;
    // A simultaneous write wins over the read, so no read is registered then.
    assign rd_hit = RD && !WR && hit;

    assign fifo_push = wr_hit && (off == OFF_TXDATA);
    assign ovf_clr   = wr_hit && (off == OFF_STATUS) && DataIn[ST_OVF];
    assign irq_clr   = wr_hit && (off == OFF_STATUS) && DataIn[ST_IRQ];
    assign match     = ten_reg && (timer_reg == cmp_reg);
    assign cnt_ext   = 16'(fifo_count);

    mmio_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (Clk1),
        .rst_n (Reset_n),
        .push  (fifo_push),
        .din   (DataIn),
        .pop   (TxReady),
        .dout  (TxData),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    always_comb begin
        rdata = 16'h0000;
        case (off)
            OFF_STATUS: rdata = pack_status(irq_reg, cnt_ext[3:0], ovf_reg, fifo_full, fifo_empty);
            OFF_TIMER:  rdata = timer_reg;
            OFF_CMP:    rdata = cmp_reg;
            OFF_CTRL:   rdata = {15'b0, ten_reg};
            default:    rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            timer_reg <= '0;
            cmp_reg   <= '0;
            ten_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            irq_reg   <= 1'b0;
            sel_reg   <= 1'b0;
            dout_reg  <= '0;
        end else begin
            // The compare above uses the pre-write timer, so a load never masks a match.
            if (wr_hit && (off == OFF_TIMER))
                timer_reg <= DataIn;
            else
                timer_reg <= timer_reg + 16'd1;

            if (wr_hit && (off == OFF_CMP))
                cmp_reg <= DataIn;
            if (wr_hit && (off == OFF_CTRL))
                ten_reg <= DataIn[0];

            if (fifo_drop)
                ovf_reg <= 1'b1;
            else if (ovf_clr)
                ovf_reg <= 1'b0;

            if (match)
                irq_reg <= 1'b1;
            else if (irq_clr)
                irq_reg <= 1'b0;

            sel_reg <= rd_hit;
            if (rd_hit)
                dout_reg <= rdata;
        end
    end

    assign DataOut = dout_reg;
    assign Sel     = sel_reg;
    assign TxValid = !fifo_empty;
    assign Irq     = irq_reg;

endmodule

// File: tb/tb_mmio_resp.sv
// Self-checking bench for mmio_resp: scoreboards for bus reads and TX pops,
// plus per-scenario inline checks of Sel, Irq and FIFO flags.
module tb_mmio_resp;

    logic        Clk1 = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] Addr = 16'h0000;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [15:0] DataIn = 16'h0000;
    logic [15:0] DataOut;
    logic        Sel;
    logic [15:0] TxData;
    logic        TxValid;
    logic        TxReady = 1'b0;
    logic        Irq;

    int total = 0;
    int bad   = 0;

    logic [15:0] tx_q[$];
    logic [15:0] rd_q[$];
    string       rd_name_q[$];
    logic [15:0] tx_exp, rd_exp;
    string       rd_name;

    mmio_resp #(
        .BASE  (16'hFF00),
        .DEPTH (8)
    ) dut (
        .Clk1    (Clk1),
        .Reset_n (Reset_n),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .Sel     (Sel),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .Irq     (Irq)
    );

    always #5 Clk1 = ~Clk1;

    // TX scoreboard: a pop happens on the next rising edge whenever valid and ready are high.
    always @(negedge Clk1) begin
        if (Reset_n && TxValid && TxReady) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_pop: got %h, expected no pop", TxData);
            end else begin
                tx_exp = tx_q.pop_front();
                if (TxData !== tx_exp) begin
                    bad++;
                    $display("FAIL tx_pop: got %h, expected %h", TxData, tx_exp);
                end else
                    $display("tx pop %h ok", TxData);
            end
        end
    end

    // Read scoreboard: Sel marks the cycle in which DataOut carries a read result.
    always @(negedge Clk1) begin
        if (Reset_n && Sel) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_sel: Sel=1 with no read issued, DataOut=%h", DataOut);
            end else begin
                rd_exp  = rd_q.pop_front();
                rd_name = rd_name_q.pop_front();
                if (DataOut !== rd_exp) begin
                    bad++;
                    $display("FAIL %s: got %h, expected %h", rd_name, DataOut, rd_exp);
                end else
                    $display("read %s = %h ok", rd_name, DataOut);
            end
        end
    end

    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        Addr   = a;
        DataIn = d;
        WR     = 1'b1;
        tick();
        WR     = 1'b0;
    endtask

    task automatic fifo_push(input logic [15:0] d, input bit accept);
        if (accept)
            tx_q.push_back(d);
        bus_write(16'hFF00, d);
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string name);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        Addr = a;
        RD   = 1'b1;
        tick();
        RD   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total += 5;
        if (DataOut !== 16'h0) begin bad++; $display("FAIL rst_dataout: got %h, expected 0000", DataOut); end
        if (Sel !== 1'b0)      begin bad++; $display("FAIL rst_sel: got %b, expected 0", Sel); end
        if (TxValid !== 1'b0)  begin bad++; $display("FAIL rst_txvalid: got %b, expected 0", TxValid); end
        if (TxData !== 16'h0)  begin bad++; $display("FAIL rst_txdata: got %h, expected 0000", TxData); end
        if (Irq !== 1'b0)      begin bad++; $display("FAIL rst_irq: got %b, expected 0", Irq); end
        $display("reset state checked");
        @(negedge Clk1);
        Reset_n = 1'b1;
        tick();
        bus_read(16'hFF01, 16'h0001, "rst_status");
        bus_read(16'hFF03, 16'h0000, "rst_cmp");
        bus_read(16'hFF04, 16'h0000, "rst_ctrl");
    endtask

    task automatic test_fifo_basic();
        TxReady = 1'b0;
        fifo_push(16'h1111, 1'b1);
        fifo_push(16'h2222, 1'b1);
        fifo_push(16'h3333, 1'b1);
        total += 2;
        if (TxValid !== 1'b1)    begin bad++; $display("FAIL fifo_valid: got %b, expected 1", TxValid); end
        if (TxData !== 16'h1111) begin bad++; $display("FAIL fifo_head: got %h, expected 1111", TxData); end
        $display("fifo head %h valid %b", TxData, TxValid);
        bus_read(16'hFF01, 16'h0018, "status_cnt3");
        TxReady = 1'b1;
        repeat (3) tick();
        TxReady = 1'b0;
        bus_read(16'hFF01, 16'h0001, "status_drained");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++)
            fifo_push(16'h1000 + 16'(i), i < 8);
        bus_read(16'hFF01, 16'h0046, "status_ovf_full");
        bus_write(16'hFF01, 16'h0004);
        bus_read(16'hFF01, 16'h0042, "status_ovf_clr");
    endtask

    task automatic test_full_push_pop();
        TxReady = 1'b1;
        fifo_push(16'hA5A5, 1'b1);
        TxReady = 1'b0;
        bus_read(16'hFF01, 16'h0042, "status_full_pushpop");
        TxReady = 1'b1;
        repeat (8) tick();
        TxReady = 1'b0;
        total++;
        if (tx_q.size() != 0) begin bad++; $display("FAIL full_drain: %0d words left, expected 0", tx_q.size()); end
        bus_read(16'hFF01, 16'h0001, "status_after_drain");
    endtask

    task automatic test_irq();
        bus_write(16'hFF03, 16'h0010);
        bus_write(16'hFF04, 16'h0001);
        bus_write(16'hFF02, 16'h0000);
        repeat (16) tick();
        total++;
        if (Irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b, expected 0", Irq); end
        tick();
        total++;
        if (Irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b, expected 1", Irq); end
        $display("irq rose on match edge: %b", Irq);
        bus_write(16'hFF01, 16'h0080);
        total++;
        if (Irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b, expected 0", Irq); end
        // Clear coinciding with a match: set must win.
        bus_write(16'hFF02, 16'h000E);
        tick();
        tick();
        bus_write(16'hFF01, 16'h0080);
        total++;
        if (Irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got %b, expected 1", Irq); end
        bus_write(16'hFF01, 16'h0080);
        total++;
        if (Irq !== 1'b0) begin bad++; $display("FAIL irq_clear2: got %b, expected 0", Irq); end
        // Timer load on a match edge: match uses the old value, load wins over increment.
        bus_write(16'hFF02, 16'h000F);
        tick();
        bus_write(16'hFF02, 16'h1234);
        total++;
        if (Irq !== 1'b1) begin bad++; $display("FAIL irq_write_match: got %b, expected 1", Irq); end
        bus_read(16'hFF02, 16'h1234, "timer_load_on_match");
        bus_write(16'hFF04, 16'h0000);
        bus_write(16'hFF01, 16'h0080);
        total++;
        if (Irq !== 1'b0) begin bad++; $display("FAIL irq_final_clear: got %b, expected 0", Irq); end
        bus_write(16'hFF02, 16'hFFFF);
        bus_read(16'hFF02, 16'hFFFF, "timer_ffff");
        bus_read(16'hFF02, 16'h0000, "timer_wrap");
        bus_read(16'hFF04, 16'h0000, "ctrl_off");
        bus_read(16'hFF03, 16'h0010, "cmp_readback");
    endtask

    task automatic test_decode();
        bus_write(16'hFF03, 16'hBEEF);
        bus_read(16'hFF03, 16'hBEEF, "cmp_beef");
        Addr = 16'h1234;
        RD   = 1'b1;
        tick();
        RD   = 1'b0;
        total += 2;
        if (Sel !== 1'b0)        begin bad++; $display("FAIL miss_sel: got %b, expected 0", Sel); end
        if (DataOut !== 16'hBEEF) begin bad++; $display("FAIL miss_hold: got %h, expected beef", DataOut); end
        $display("miss read at 1234: Sel=%b DataOut=%h", Sel, DataOut);
        Addr   = 16'hFF02;
        DataIn = 16'h0100;
        RD     = 1'b1;
        WR     = 1'b1;
        tick();
        RD     = 1'b0;
        WR     = 1'b0;
        total += 2;
        if (Sel !== 1'b0)        begin bad++; $display("FAIL rdwr_sel: got %b, expected 0", Sel); end
        if (DataOut !== 16'hBEEF) begin bad++; $display("FAIL rdwr_hold: got %h, expected beef", DataOut); end
        $display("rd+wr at ff02: Sel=%b", Sel);
        bus_read(16'hFF02, 16'h0100, "timer_rdwr_loaded");
        bus_read(16'hFF07, 16'h0000, "unused_off7");
        bus_write(16'hFF07, 16'h5555);
        bus_read(16'hFF07, 16'h0000, "unused_off7_wr");
        bus_write(16'hFF04, 16'hFFFE);
        bus_read(16'hFF04, 16'h0000, "ctrl_bit0_only");
        bus_read(16'hFF00, 16'h0000, "txdata_read");
        tick();
        total += 2;
        if (Sel !== 1'b0)        begin bad++; $display("FAIL sel_one_cycle: got %b, expected 0", Sel); end
        if (DataOut !== 16'h0000) begin bad++; $display("FAIL dataout_hold: got %h, expected 0000", DataOut); end
    endtask

    task automatic test_reset_mid();
        bus_write(16'hFF03, 16'h0040);
        bus_write(16'hFF04, 16'h0001);
        fifo_push(16'h7001, 1'b1);
        fifo_push(16'h7002, 1'b1);
        fifo_push(16'h7003, 1'b1);
        bus_write(16'hFF02, 16'h0040);
        tick();
        total += 2;
        if (Irq !== 1'b1)     begin bad++; $display("FAIL pre_rst_irq: got %b, expected 1", Irq); end
        if (TxValid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid: got %b, expected 1", TxValid); end
        #2;
        Reset_n = 1'b0;
        #1;
        total += 3;
        if (TxValid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b, expected 0", TxValid); end
        if (Irq !== 1'b0)     begin bad++; $display("FAIL mid_rst_irq: got %b, expected 0", Irq); end
        if (TxData !== 16'h0) begin bad++; $display("FAIL mid_rst_txdata: got %h, expected 0000", TxData); end
        $display("mid-op reset: TxValid=%b Irq=%b", TxValid, Irq);
        tx_q.delete();
        TxReady = 1'b1;
        @(negedge Clk1);
        Reset_n = 1'b1;
        tick();
        TxReady = 1'b0;
        bus_read(16'hFF01, 16'h0001, "status_after_reset");
        tick();
    endtask

    initial begin
        test_reset();
        test_fifo_basic();
        test_overflow();
        test_full_push_pop();
        test_irq();
        test_decode();
        test_reset_mid();
        total += 2;
        if (rd_q.size() != 0) begin bad++; $display("FAIL rd_pending: %0d reads never returned", rd_q.size()); end
        if (tx_q.size() != 0) begin bad++; $display("FAIL tx_pending: %0d words never popped", tx_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_resp.md
MMIO_RESP -- requirements
Module: mmio_resp

Interface
REQ-001 SHALL have parameter BASE, default 16'hFF00: base address of the 16-word MMIO window.
REQ-002 SHALL have parameter DEPTH, default 8: TX FIFO depth in 16-bit words.
REQ-003 SHALL have port Clk1, input, 1: single clock, rising-edge active.
REQ-004 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port Addr, input, 16: bus address from CVP14.
REQ-006 SHALL have port RD, input, 1: read strobe.
REQ-007 SHALL have port WR, input, 1: write strobe.
REQ-008 SHALL have port DataIn, input, 16: write data, driven from CVP14 DataOut.
REQ-009 SHALL have port DataOut, output, 16: read data, returned to CVP14 DataIn through the system mux.
REQ-010 SHALL have port Sel, output, 1: registered window hit, which steers the system read mux away from DRAM.
REQ-011 SHALL have port TxData, output, 16: FIFO head word.
REQ-012 SHALL have port TxValid, output, 1: FIFO non-empty.
REQ-013 SHALL have port TxReady, input, 1: sink accepts the head word.
REQ-014 SHALL have port Irq, output, 1: sticky timer-compare flag.

Function
REQ-015 SHALL decode a hit when Addr[15:4]==BASE[15:4]; offset is Addr[3:0].
REQ-016 Offset 0 TXDATA SHALL behave as follows: a write pushes DataIn into the FIFO; a read returns 0.
REQ-017 Offset 1 STATUS SHALL read {8'b0, IRQ, CNT[3:0], OVF, FULL, EMPTY}, with IRQ at bit 7.
REQ-018 On a STATUS write, bit2=1 SHALL clear OVF and bit7=1 SHALL clear IRQ (write-1-to-clear); other bits SHALL be ignored.
REQ-019 Offset 2 TIMER SHALL be a free-running 16-bit up-counter that wraps from FFFF to 0000; a write loads DataIn, and the counter continues from the loaded value on the next cycle.
REQ-020 Offset 3 CMP SHALL be a read/write 16-bit register; offset 4 CTRL bit0 SHALL be the compare enable (TEN), with other bits reading 0.
REQ-021 Offsets 5-15 SHALL read 0, and writes to them SHALL be ignored.
REQ-022 Read latency SHALL be 1 cycle: DataOut and Sel SHALL be registered on the edge where RD is high and a hit is decoded.
REQ-023 DataOut SHALL hold its value until the next hit read; Sel SHALL be 1 for exactly the cycle after a hit read.
REQ-024 A read SHALL return the register value before that edge's update; a TIMER read SHALL return the pre-increment value.
REQ-025 If RD and WR are both high, the write SHALL take effect, no read SHALL occur, and Sel SHALL be 0 next cycle.
REQ-026 A non-hit access SHALL change no state and SHALL drive Sel to 0 next cycle.
REQ-027 FIFO pop SHALL occur when TxValid && TxReady; TxData SHALL be the head word, combinational from storage.
REQ-028 Push while full with no pop SHALL drop the word and set OVF (sticky); CNT SHALL be unchanged.
REQ-029 Push while full with a pop in the same cycle SHALL accept the word, and CNT SHALL remain DEPTH.
REQ-030 Push and pop in the same cycle when non-empty and not full SHALL leave CNT unchanged.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 Irq SHALL set on the edge where TEN=1 and TIMER==CMP, and SHALL hold until cleared.
REQ-033 If set and clear of Irq occur in the same cycle, set SHALL win.
REQ-034 A TIMER write in the same cycle as a match SHALL take priority over the increment; the match SHALL still be evaluated on the pre-write value.

Reset
REQ-035 While Reset_n is low, all of the following SHALL hold: DataOut=0, Sel=0, TxValid=0, TxData=0, Irq=0; FIFO empty, OVF=0, TIMER=0, CMP=0, TEN=0.
REQ-036 Reset assertion mid-operation SHALL discard FIFO contents immediately (asynchronously); no pop SHALL be reported on the release edge.

Structure
REQ-037 Shared package cvp14_mmio_pkg SHALL hold the offset constants, STATUS bit positions, and the defaults for BASE and DEPTH.
REQ-038 Storage and pointers SHALL live in one sub-module, mmio_fifo (push/pop/full/empty/count); register decode, timer and Irq SHALL live in mmio_resp.

Verification
REQ-039 Write FF00=1111, 2222, 3333 with TxReady=0 -> TxValid=1, TxData=1111, STATUS reads 0x0018 (CNT=3); raise TxReady for 3 cycles -> 1111, 2222, 3333 popped, STATUS reads 0x0001.
REQ-040 Write 9 words with TxReady=0 -> 9th dropped, STATUS reads 0x0046 (CNT=8, OVF, FULL); write FF01=0004 -> OVF cleared, STATUS reads 0x0042.
REQ-041 Full FIFO, push A5A5 with TxReady=1 in the same cycle -> CNT stays 8, OVF=0, A5A5 is the last word popped.
REQ-042 Write CMP=0010, CTRL=1, TIMER=0000 -> Irq rises on the edge where TIMER==0010; write FF01=0080 -> Irq=0; TIMER=FFFF wraps to 0000 on the next cycle.
REQ-043 RD at 0x1234 -> Sel=0 and DataOut holds its last value; RD and WR both high at FF02 -> TIMER loaded, Sel=0 next cycle; RD at FF07 -> DataOut=0000 with Sel=1.
REQ-044 Pulse Reset_n low with 3 words queued and Irq=1 -> TxValid=0 and Irq=0 immediately, and STATUS reads 0x0001 after release.
